// File: rtl/shift_pipe_pkg.sv
// Shared mode/direction constants and the bit-reverse helper used by the
// pipelined barrel shifter.
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_RSVD  = 2'b11
  } sh_mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int MAX_WIDTH = 64;

  // Reverses the low 'width' bits of v; bits above 'width' come back as zero.
  function automatic logic [MAX_WIDTH-1:0] bit_rev(input logic [MAX_WIDTH-1:0] v,
                                                   input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Request/response bundle of the pipelined shifter; the shifter is the slave,
// the operand source and result sink together act as the master.
interface shift_pipe_if #(parameter int WIDTH = 32);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic             sh_dir;
  logic [1:0]       sh_mode;
  logic [AMT_W-1:0] sh_amt;
  logic [WIDTH-1:0] d_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d_out;
  logic             out_zero;

  modport master (
    output in_valid, sh_dir, sh_mode, sh_amt, d_in, out_ready,
    input  in_ready, out_valid, d_out, out_zero
  );

  modport slave (
    input  in_valid, sh_dir, sh_mode, sh_amt, d_in, out_ready,
    output in_ready, out_valid, d_out, out_zero
  );
endinterface

// File: rtl/shift_pipe_stage.sv
// One shifter stage: conditional left shift/rotate by 2**STAGE followed by
// the stage register. Right shifts arrive here already bit-reversed.
module shift_pipe_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adv,
  input  logic                     up_valid,
  input  logic                     up_dir,
  input  logic [1:0]               up_mode,
  input  logic [$clog2(WIDTH)-1:0] up_amt,
  input  logic [WIDTH-1:0]         up_data,
  output logic                     valid,
  output logic                     dir,
  output logic [1:0]               mode,
  output logic [$clog2(WIDTH)-1:0] amt,
  output logic [WIDTH-1:0]         data
);

  localparam int SHIFT = 1 << STAGE;

  logic             fill;
  logic [WIDTH-1:0] shifted;

  // In the reversed domain the original sign bit sits at bit 0 and stays
  // there, so arithmetic right shifts keep refilling from data[0].
  always_comb begin
    fill    = 1'b0;
    shifted = up_data;
    if (up_mode == MODE_ARITH && up_dir == DIR_RIGHT) fill = up_data[0];
    if (up_amt[STAGE]) begin
      if (up_mode == MODE_ROT)
        shifted = {up_data[WIDTH-1-SHIFT:0], up_data[WIDTH-1 -: SHIFT]};
      else
        shifted = {up_data[WIDTH-1-SHIFT:0], {SHIFT{fill}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dir   <= 1'b0;
      mode  <= '0;
      amt   <= '0;
      data  <= '0;
    end else if (adv) begin
      valid <= up_valid;
      dir   <= up_dir;
      mode  <= up_mode;
      amt   <= up_amt;
      data  <= shifted;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one stage per shift-amount bit, whole pipe
// advances together whenever the output slot is free or being drained.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_pipe_if.slave bus
);

  localparam int AMT_W = $clog2(WIDTH);

  logic                 adv;
  logic                 valid_s [AMT_W+1];
  logic                 dir_s   [AMT_W+1];
  logic [1:0]           mode_s  [AMT_W+1];
  logic [AMT_W-1:0]     amt_s   [AMT_W+1];
  logic [WIDTH-1:0]     data_s  [AMT_W+1];
  logic [MAX_WIDTH-1:0] rev_in;
  logic [MAX_WIDTH-1:0] rev_out;
  logic                 unused_tail;

  // Right shifts run as reverse / left shift / reverse.
  assign rev_in     = bit_rev(MAX_WIDTH'(bus.d_in), WIDTH);
  assign valid_s[0] = bus.in_valid;
  assign dir_s[0]   = bus.sh_dir;
  assign mode_s[0]  = bus.sh_mode;
  assign amt_s[0]   = bus.sh_amt;
  assign data_s[0]  = (bus.sh_dir == DIR_RIGHT) ? rev_in[WIDTH-1:0] : bus.d_in;

  generate
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
      shift_pipe_stage #(
        .WIDTH (WIDTH),
        .STAGE (k)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .up_valid (valid_s[k]),
        .up_dir   (dir_s[k]),
        .up_mode  (mode_s[k]),
        .up_amt   (amt_s[k]),
        .up_data  (data_s[k]),
        .valid    (valid_s[k+1]),
        .dir      (dir_s[k+1]),
        .mode     (mode_s[k+1]),
        .amt      (amt_s[k+1]),
        .data     (data_s[k+1])
      );
    end
  endgenerate

  assign rev_out = bit_rev(MAX_WIDTH'(data_s[AMT_W]), WIDTH);

  assign adv           = !valid_s[AMT_W] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_s[AMT_W];
  assign bus.d_out     = (dir_s[AMT_W] == DIR_RIGHT) ? rev_out[WIDTH-1:0] : data_s[AMT_W];
  assign bus.out_zero  = valid_s[AMT_W] && (data_s[AMT_W] == '0);

  // Mode/amount are spent by the last stage; upper reverse bits are padding.
  assign unused_tail = ^{rev_in, rev_out, mode_s[AMT_W], amt_s[AMT_W]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and swept checks of shift_pipe at WIDTH=32: latency, fill rules,
// backpressure hold, ordering and asynchronous reset flush.
module tb_shift_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_pipe_if #(.WIDTH(32)) bus ();

  shift_pipe #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream vectors with hand-computed results.
  logic        vecDir  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0]  vecMode [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
  logic [4:0]  vecAmt  [8] = '{5'd4, 5'd8, 5'd8, 5'd16, 5'd4, 5'd1, 5'd3, 5'd0};
  logic [31:0] vecD    [8] = '{32'h0000_00F1, 32'h1234_5678, 32'h8765_4321, 32'h1234_5678,
                               32'h1234_5678, 32'hC000_0001, 32'h8000_0010, 32'h8000_0000};
  logic [31:0] vecExp  [8] = '{32'h0000_0F10, 32'h0012_3456, 32'hFF87_6543, 32'h5678_1234,
                               32'h8123_4567, 32'h8000_0002, 32'h1000_0002, 32'h8000_0000};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refShift(input logic dir, input logic [1:0] mode,
                                           input logic [4:0] amt, input logic [31:0] d);
    logic [5:0] back;
    back = 6'd32 - {1'b0, amt};
    if (amt == 5'd0) return d;
    if (mode == 2'b10) return dir ? ((d >> amt) | (d << back)) : ((d << amt) | (d >> back));
    if (mode == 2'b01 && dir) return $signed(d) >>> amt;
    return dir ? (d >> amt) : (d << amt);
  endfunction

  // Single request into an idle pipe; checks latency, data and zero flag.
  task automatic applyStimulus(input string tag, input logic dir, input logic [1:0] mode,
                               input logic [4:0] amt, input logic [31:0] d, input logic [31:0] exp);
    int lat;
    lat = 0;
    bus.out_ready = 1'b1;
    bus.sh_dir    = dir;
    bus.sh_mode   = mode;
    bus.sh_amt    = amt;
    bus.d_in      = d;
    bus.in_valid  = 1'b1;
    do begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 20);
    checkOutput({tag, "/lat"}, 32'(lat), 32'd5);
    checkOutput({tag, "/vld"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "/dat"}, bus.d_out, exp);
    checkOutput({tag, "/zro"}, 32'(bus.out_zero), 32'(exp == 32'd0));
    @(posedge clk);
    #1;
  endtask

  task automatic streamTest();
    logic [31:0] expQ[$];
    logic [31:0] head;
    int sent;
    int got;
    int cyc;
    bit stall;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 8 && cyc < 60) begin
      stall = (cyc >= 6 && cyc <= 9);
      bus.out_ready = !stall;
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.sh_dir   = vecDir[sent];
        bus.sh_mode  = vecMode[sent];
        bus.sh_amt   = vecAmt[sent];
        bus.d_in     = vecD[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      head = (expQ.size() > 0) ? expQ[0] : 32'hDEAD_BEEF;
      if (stall && bus.out_valid) begin
        checkOutput($sformatf("stall%0d/rdy", cyc), 32'(bus.in_ready), 32'd0);
        checkOutput($sformatf("stall%0d/hold", cyc), bus.d_out, head);
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput($sformatf("strm%0d", got), bus.d_out, head);
        if (expQ.size() > 0) void'(expQ.pop_front());
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(vecExp[sent]);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("strm/cnt", 32'(got), 32'd8);
    checkOutput("strm/dup", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic resetTest();
    int waitCyc;
    int stale;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.sh_dir   = 1'b0;
      bus.sh_mode  = 2'b00;
      bus.sh_amt   = 5'(i + 1);
      bus.d_in     = 32'h0000_0101;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    waitCyc = 0;
    while (!bus.out_valid && waitCyc < 10) begin
      @(posedge clk);
      #1;
      waitCyc++;
    end
    checkOutput("rst/pre", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst/vld", 32'(bus.out_valid), 32'd0);
    checkOutput("rst/dat", bus.d_out, 32'd0);
    checkOutput("rst/zro", 32'(bus.out_zero), 32'd0);
    checkOutput("rst/rdy", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    checkOutput("rst/stale", 32'(stale), 32'd0);
    applyStimulus("post", 1'b1, 2'b01, 5'd4, 32'h8000_00F1, 32'hF800_000F);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        dir;
    logic [1:0]  mode;
    logic [4:0]  amt;
    logic [31:0] d;
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sh_dir    = 1'b0;
    bus.sh_mode   = 2'b00;
    bus.sh_amt    = 5'd0;
    bus.d_in      = 32'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init/vld", 32'(bus.out_valid), 32'd0);
    checkOutput("init/dat", bus.d_out, 32'd0);
    checkOutput("init/zro", 32'(bus.out_zero), 32'd0);
    checkOutput("init/rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("asr4",  1'b1, 2'b01, 5'd4,  32'h8000_00F1, 32'hF800_000F);
    applyStimulus("rol1",  1'b0, 2'b10, 5'd1,  32'h8000_0001, 32'h0000_0003);
    applyStimulus("ror31", 1'b1, 2'b10, 5'd31, 32'h8000_0001, 32'h0000_0003);
    applyStimulus("lsl31", 1'b0, 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
    applyStimulus("lsr1",  1'b1, 2'b00, 5'd1,  32'h0000_0001, 32'h0000_0000);
    applyStimulus("rsvd",  1'b1, 2'b11, 5'd4,  32'h8000_00F1, 32'h0800_000F);
    applyStimulus("asl4",  1'b0, 2'b01, 5'd4,  32'h8000_00F1, 32'h0000_0F10);

    streamTest();
    resetTest();

    for (int i = 0; i < 40; i++) begin
      mode = 2'(i % 4);
      dir  = 1'((i / 4) % 2);
      amt  = (i % 8 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      d    = $urandom;
      applyStimulus($sformatf("sw%0d", i), dir, mode, amt, d, refShift(dir, mode, amt, d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
